// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - duty ramp sequencer feeding pwm.duty
// Optional macro PWM_RAMP_PERIOD_SYNC_EN defers each step to the next period_start pulse.
module pwm_ramp_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 enable_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [WIDTH-1:0]     cmd_target_i,
   input  logic [WIDTH-1:0]     cmd_step_i,
   input  logic [DIV_WIDTH-1:0] rate_div_i,
   input  logic                 period_start_i,
   output logic [WIDTH-1:0]     duty_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [1:0] {IDLE, HOLD, RAMP_UP, RAMP_DOWN} state_e;

   state_e               state_q;
   logic [WIDTH-1:0]     duty_q, target_q, step_q;
   logic [DIV_WIDTH-1:0] presc_q;
   logic                 busy_q, done_q, ready_q;

   logic                 ramping, tick, apply, accept;
   logic [WIDTH-1:0]     eff_step, next_duty_d;
   logic [WIDTH:0]       up_sum, dn_diff;

   assign ramping  = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
   assign accept   = cmd_valid_i && ready_q;
   assign tick     = ramping && enable_i && (presc_q == rate_div_i);
   assign eff_step = (cmd_step_i == '0) ? WIDTH'(1) : cmd_step_i;

   // One extra bit so the sum/difference cannot wrap before clamping to target.
   assign up_sum  = {1'b0, duty_q} + {1'b0, step_q};
   assign dn_diff = {1'b0, duty_q} - {1'b0, step_q};

   always_comb begin
      next_duty_d = duty_q;
      if (state_q == RAMP_UP) begin
         next_duty_d = (up_sum > {1'b0, target_q}) ? target_q : up_sum[WIDTH-1:0];
      end else if (state_q == RAMP_DOWN) begin
         next_duty_d = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < target_q)) ?
                       target_q : dn_diff[WIDTH-1:0];
      end
   end

`ifdef PWM_RAMP_PERIOD_SYNC_EN
   logic pending_q;
   assign apply = ramping && enable_i && period_start_i && (pending_q || tick);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pending_q <= 1'b0;
      end else if (accept) begin
         pending_q <= 1'b0;
      end else if (ramping && enable_i) begin
         if (apply) begin
            pending_q <= 1'b0;
         end else if (tick) begin
            pending_q <= 1'b1;
         end
      end
   end
`else
   logic unused_period_start;
   assign unused_period_start = period_start_i;
   assign apply = tick;
`endif

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= IDLE;
         duty_q   <= '0;
         target_q <= '0;
         step_q   <= WIDTH'(1);
         presc_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            target_q <= cmd_target_i;
            step_q   <= eff_step;
            presc_q  <= '0;
            if (cmd_target_i > duty_q) begin
               state_q <= RAMP_UP;
               busy_q  <= 1'b1;
               ready_q <= 1'b0;
            end else if (cmd_target_i < duty_q) begin
               state_q <= RAMP_DOWN;
               busy_q  <= 1'b1;
               ready_q <= 1'b0;
            end else begin
               state_q <= HOLD;
               done_q  <= 1'b1;
            end
         end else if (ramping && enable_i) begin
            presc_q <= tick ? '0 : presc_q + DIV_WIDTH'(1);
            if (apply) begin
               duty_q <= next_duty_d;
               if (next_duty_d == target_q) begin
                  state_q <= HOLD;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
         end
      end
   end

   assign duty_o      = duty_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign cmd_ready_o = ready_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - self-checking bench for pwm_ramp_ctrl
// Honours PWM_RAMP_PERIOD_SYNC_EN in its reference model; fixed-value ramps run only without it.
module tb_pwm_ramp_ctrl;
   localparam int W  = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          period_start = 1'b0;
   logic [W-1:0]  cmd_target = '0;
   logic [W-1:0]  cmd_step = '0;
   logic [DW-1:0] rate_div = '0;
   logic          cmd_ready, busy, done;
   logic [W-1:0]  duty;

   int n_cmp = 0;
   int n_fail = 0;

   int m_duty, m_tgt, m_step, m_cnt;
   bit m_busy, m_done, m_pend, m_tick;

   pwm_ramp_ctrl #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
      .clk_i          (clk),
      .reset_n_i      (rst_n),
      .enable_i       (enable),
      .cmd_valid_i    (cmd_valid),
      .cmd_ready_o    (cmd_ready),
      .cmd_target_i   (cmd_target),
      .cmd_step_i     (cmd_step),
      .rate_div_i     (rate_div),
      .period_start_i (period_start),
      .duty_o         (duty),
      .busy_o         (busy),
      .done_o         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a ramp moves duty one clamped step toward target every rate_div+1 enabled cycles.
   task automatic model_move();
      if (m_tgt > m_duty) m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
      else                m_duty = (m_duty - m_step < m_tgt) ? m_tgt : m_duty - m_step;
      if (m_duty == m_tgt) begin
         m_busy = 1'b0;
         m_done = 1'b1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_duty = 0; m_tgt = 0; m_step = 1; m_cnt = 0;
         m_busy = 1'b0; m_done = 1'b0; m_pend = 1'b0;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (cmd_valid) begin
               m_tgt  = int'(cmd_target);
               m_step = (cmd_step == '0) ? 1 : int'(cmd_step);
               m_cnt  = 0;
               m_pend = 1'b0;
               if (m_tgt == m_duty) m_done = 1'b1;
               else                 m_busy = 1'b1;
            end
         end else if (enable) begin
            m_cnt++;
            m_tick = (m_cnt == int'(rate_div) + 1);
            if (m_tick) m_cnt = 0;
`ifdef PWM_RAMP_PERIOD_SYNC_EN
            if (period_start && (m_pend || m_tick)) begin
               m_pend = 1'b0;
               model_move();
            end else if (m_tick) begin
               m_pend = 1'b1;
            end
`else
            if (m_tick) model_move();
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("duty",      int'(duty),      m_duty);
         check("busy",      int'(busy),      int'(m_busy));
         check("cmd_ready", int'(cmd_ready), int'(!m_busy));
         check("done",      int'(done),      int'(m_done));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input int t, input int s);
      cmd_valid  = 1'b1;
      cmd_target = W'(t);
      cmd_step   = W'(s);
      cyc(1);
      cmd_valid  = 1'b0;
   endtask

   initial begin
      cyc(3);
      check("rst_duty", int'(duty), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n = 1'b1;
      cyc(1);
      enable = 1'b1;

`ifndef PWM_RAMP_PERIOD_SYNC_EN
      rate_div = DW'(3);
      issue(40, 16);
      check("up_busy", int'(busy), 1);
      check("up_ready", int'(cmd_ready), 0);
      cyc(3); check("up_d0", int'(duty), 0);
      cyc(1); check("up_d16", int'(duty), 16);
      cyc(4); check("up_d32", int'(duty), 32);
      cyc(3); check("up_ready_mid", int'(cmd_ready), 0);
      cyc(1); check("up_d40", int'(duty), 40);
      check("up_done", int'(done), 1);
      check("up_ready_end", int'(cmd_ready), 1);
      cyc(1); check("up_done_pulse", int'(done), 0);

      rate_div = DW'(0);
      issue(255, 255);
      cyc(1); check("sat_255", int'(duty), 255);
      issue(5, 100);
      cyc(1); check("dn_155", int'(duty), 155);
      cyc(1); check("dn_55", int'(duty), 55);
      cyc(1); check("dn_5", int'(duty), 5);
      check("dn_done", int'(done), 1);
      issue(10, 5);
      cyc(1);
      issue(13, 0);
      cyc(1); check("s0_11", int'(duty), 11);
      cyc(1); check("s0_12", int'(duty), 12);
      cyc(1); check("s0_13", int'(duty), 13);

      issue(64, 64);
      cyc(1); check("clamp_64", int'(duty), 64);
      issue(64, 3);
      check("eq_done", int'(done), 1);
      check("eq_duty", int'(duty), 64);
      check("eq_busy", int'(busy), 0);
      cyc(1); check("eq_done_pulse", int'(done), 0);

      cmd_valid = 1'b1; cmd_target = W'(200); cmd_step = W'(1);
      cyc(1);
      cmd_target = W'(0);
      cyc(10);
      cmd_valid = 1'b0;
      check("retgt_duty", int'(duty), 74);
      check("retgt_busy", int'(busy), 1);
      cyc(126); check("retgt_end", int'(duty), 200);
      check("retgt_done", int'(done), 1);

      rate_div = DW'(3);
      issue(100, 20);
      cyc(6);
      enable = 1'b0;
      cyc(20);
      check("frz_duty", int'(duty), 180);
      enable = 1'b1;
      cyc(1); check("frz_hold", int'(duty), 180);
      cyc(1); check("frz_resume", int'(duty), 160);
      cyc(2);
`endif

      issue(250, 7);
      cyc(2);
      #3 rst_n = 1'b0;
      #1;
      check("arst_duty", int'(duty), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_ready", int'(cmd_ready), 1);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);

      for (int i = 0; i < 4000; i++) begin
         enable       = ($urandom_range(0, 9) != 0);
         period_start = ($urandom_range(0, 7) == 0);
         if (!m_busy) rate_div = DW'($urandom_range(0, 4));
         cmd_valid  = ($urandom_range(0, 3) == 0);
         cmd_target = ($urandom_range(0, 7) == 0) ? W'(m_duty) : W'($urandom);
         cmd_step   = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(0, 80));
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         cyc(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
